// File: rtl/fpa_norm_round.sv
// Normalize-and-round stage behind the fpa adder: shifts the raw mantissa left one bit per
// cycle, rounds to nearest-even and packs an IEEE-754 single with a valid/ready handshake.
module fpa_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mantis,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 28;
  localparam int unsigned FRAC_W = 23;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state;
  logic               sign_q;
  logic [EXP_W-1:0]   exp_q;
  logic [MAN_W-1:0]   mant_q;

  logic               rnd_up;
  logic               rnd_carry;
  logic [FRAC_W-1:0]  rnd_frac;
  logic [EXP_W:0]     rnd_exp;
  logic               rnd_inexact;

  assign in_ready = (state == IDLE);

  // Nearest-even rounding on the 23 fraction bits; a carry out of the fraction means the
  // 24-bit significand wrapped to 1.0 and the exponent steps up.
  always_comb begin
    rnd_up      = 1'b0;
    rnd_carry   = 1'b0;
    rnd_frac    = '0;
    rnd_exp     = '0;
    rnd_inexact = 1'b0;
    rnd_up      = mant_q[3] & (mant_q[4] | (|mant_q[2:0]));
    rnd_inexact = |mant_q[3:0];
    {rnd_carry, rnd_frac} = (FRAC_W+1)'({1'b0, mant_q[26:4]}) + (FRAC_W+1)'(rnd_up);
    rnd_exp     = (EXP_W+1)'(exp_q) + (EXP_W+1)'(rnd_carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= in_exp;
            mant_q <= in_mantis;
            state  <= NORM;
          end
        end
        NORM: begin
          if (exp_q == 8'd255) begin
            result    <= {sign_q, 8'hFF, 23'd0};
            overflow  <= 1'b1;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant_q == '0 || exp_q == '0) begin
            result    <= {sign_q, 31'd0};
            overflow  <= 1'b0;
            underflow <= |mant_q;
            inexact   <= |mant_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant_q[27]) begin
            state <= ROUND;
          end else if (exp_q == 8'd1) begin
            // No denormal output: anything that would need one is flushed.
            result    <= {sign_q, 31'd0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
            inexact   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          if (rnd_exp == 9'd255) begin
            result   <= {sign_q, 8'hFF, 23'd0};
            overflow <= 1'b1;
            inexact  <= 1'b1;
          end else begin
            result   <= {sign_q, rnd_exp[7:0], rnd_frac};
            overflow <= 1'b0;
            inexact  <= rnd_inexact;
          end
          underflow <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpa_norm_round.sv
// Scoreboard bench for fpa_norm_round: directed operands push expected words, a negedge
// monitor checks result, flags, latency and hold stability whenever out_valid is high.
module tb_fpa_norm_round;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, inexact}
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mantis = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  int   cyc = 0;
  int   accept_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  fpa_norm_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: first cycle of out_valid pops and checks; later DONE cycles check hold.
  bit          seen = 1'b0;
  logic [31:0] held_res;
  logic [2:0]  held_flags;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held_res   = result;
          held_flags = {overflow, underflow, inexact};
          if (sb.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, 32'(e.res));
            check("flags", 32'({overflow, underflow, inexact}), 32'(e.flags));
            check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
          end
        end else begin
          check("hold_result", result, held_res);
          check("hold_flags", 32'({overflow, underflow, inexact}), 32'(held_flags));
          check("hold_in_ready", 32'(in_ready), 32'd0);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                      input logic [31:0] r, input logic [2:0] f, input logic [7:0] lat,
                      input bit push);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("send_wait_ready");
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mantis = m;
    if (push) sb.push_back('{res: r, flags: f, lat: lat});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_mantis  = 28'($urandom);
    in_exp     = 8'($urandom);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(sb.size() == 0 && in_ready && !out_valid) && t < 100);
    if (t >= 100) fail_now("wait_idle");
  endtask

  task automatic op(input logic s, input logic [7:0] e, input logic [27:0] m,
                    input logic [31:0] r, input logic [2:0] f, input logic [7:0] lat);
    send(s, e, m, r, f, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", 32'({overflow, underflow, inexact}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    op(1'b0, 8'd127, 28'h8000000, 32'h3F800000, 3'b000, 8'd2);
    op(1'b0, 8'd127, 28'h8000008, 32'h3F800000, 3'b001, 8'd2);
    op(1'b0, 8'd127, 28'h8000018, 32'h3F800002, 3'b001, 8'd2);
    op(1'b0, 8'd127, 28'h800000C, 32'h3F800001, 3'b001, 8'd2);
    op(1'b0, 8'd127, 28'h8000004, 32'h3F800000, 3'b001, 8'd2);
    op(1'b0, 8'd127, 28'hFFFFFF8, 32'h40000000, 3'b001, 8'd2);
    op(1'b0, 8'd254, 28'hFFFFFF8, 32'h7F800000, 3'b101, 8'd2);
    op(1'b0, 8'd130, 28'h0800000, 32'h3F000000, 3'b000, 8'd6);
    op(1'b1, 8'd130, 28'h0800000, 32'hBF000000, 3'b000, 8'd6);
    op(1'b0, 8'd2,   28'h0400000, 32'h00000000, 3'b011, 8'd2);
    op(1'b1, 8'd100, 28'h0000000, 32'h80000000, 3'b000, 8'd1);
    op(1'b1, 8'd0,   28'h8000000, 32'h80000000, 3'b011, 8'd1);
    op(1'b0, 8'd255, 28'h8000000, 32'h7F800000, 3'b100, 8'd1);
    op(1'b0, 8'd200, 28'h0000001, 32'h56800000, 3'b000, 8'd29);

    // Backpressure: result held for several cycles in DONE.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(1'b0, 8'd128, 28'h8000000, 32'h40000000, 3'b000, 8'd2, 1'b1);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) fail_now("bp_wait_valid");
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Reset mid-normalization of a 10-shift operand discards it.
    send(1'b0, 8'd130, 28'h0020000, 32'h0, 3'b000, 8'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort_no_output", 32'(out_valid), 32'd0);
    end

    op(1'b1, 8'd129, 28'h8000000, 32'hC0800000, 3'b000, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
